// File: rtl/trans_arbiter_pkg.sv
// trans_arbiter_pkg: FSM state encodings and channel indices shared by the arbiter files.
package trans_arbiter_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_MID   = 2'd2;
  localparam logic [1:0] ST_PAD   = 2'd3;
  localparam int CH0 = 0;
  localparam int CH1 = 1;
endpackage

// File: rtl/trans_arbiter_rr_pick2.sv
// trans_arbiter_rr_pick2: two-way round-robin picker, one-hot result favouring the channel not granted last.
module trans_arbiter_rr_pick2
  import trans_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] pick_o
);
  always_comb pick_o = (&req_i) ? (last_i ? 2'(1 << CH0) : 2'(1 << CH1)) : req_i;
endmodule

// File: rtl/trans_arbiter.sv
// trans_arbiter: round-robin sharing of one byte/nibble packer between two channels, with
// grant locked across nibble pairs and pad completion of abandoned pairs.
module trans_arbiter
  import trans_arbiter_pkg::*;
#(
  parameter int MAX_BURST   = 4,
  parameter int NIB_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ch0_req,
  input  logic       ch0_byte,
  input  logic [7:0] ch0_data,
  output logic       ch0_ack,
  input  logic       ch1_req,
  input  logic       ch1_byte,
  input  logic [7:0] ch1_data,
  output logic       ch1_ack,
  input  logic       fifo_afull,
  output logic       pk_start,
  output logic       pk_byte,
  output logic [7:0] pk_data,
  output logic [1:0] grant,
  output logic       pad_evt,
  output logic       busy
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(NIB_TIMEOUT + 1);
  logic [1:0] state_q, state_d, grant_q, grant_d, pick;
  logic last_q, last_d, pad_q, pad_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  logic own, o_req, o_byte, issue_ok, iss, pad_iss, ack, rel;
  logic [7:0] o_data;

  assign own      = grant_q[CH1];
  assign o_req    = own ? ch1_req : ch0_req;
  assign o_byte   = own ? ch1_byte : ch0_byte;
  assign o_data   = own ? ch1_data : ch0_data;
  assign issue_ok = o_req & ~fifo_afull;
  assign cnt_inc  = cnt_q + 1'b1;
  assign tmr_inc  = tmr_q + 1'b1;

  trans_arbiter_rr_pick2 u_pick (
    .req_i ({ch1_req, ch0_req}),
    .last_i(last_q),
    .pick_o(pick)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    pad_d   = 1'b0;
    iss     = 1'b0;
    pad_iss = 1'b0;
    ack     = 1'b0;
    rel     = 1'b0;
    case (state_q)
      ST_IDLE: if (|pick) begin
        grant_d = pick;
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = ST_GRANT;
      end
      ST_GRANT: if (!o_req || cnt_q == CW'(MAX_BURST)) rel = 1'b1;
      else if (issue_ok) begin
        iss = 1'b1;
        ack = 1'b1;
        if (o_byte) begin
          cnt_d = cnt_inc;
          rel   = cnt_inc == CW'(MAX_BURST);
        end else state_d = ST_MID;
      end
      // A byte beat here stays un-acked until the pair completes or is padded.
      ST_MID: if (issue_ok && !o_byte) begin
        iss     = 1'b1;
        ack     = 1'b1;
        cnt_d   = cnt_inc;
        tmr_d   = '0;
        state_d = ST_GRANT;
      end else if (!fifo_afull) begin
        tmr_d   = tmr_inc;
        state_d = (tmr_inc == TW'(NIB_TIMEOUT)) ? ST_PAD : ST_MID;
      end
      ST_PAD: if (!fifo_afull) begin
        pad_iss = 1'b1;
        pad_d   = 1'b1;
        rel     = 1'b1;
      end
    endcase
    if (rel) begin
      state_d = ST_IDLE;
      grant_d = '0;
      last_d  = own;
    end
  end

  // last_q holds the channel granted most recently; resetting it to ch1 makes ch0 preferred.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pad_q   <= pad_d;
    end

  assign pk_start = iss | pad_iss;
  assign pk_byte  = iss ? o_byte : ~pad_iss;
  assign pk_data  = iss ? o_data : 8'h00;
  assign ch0_ack  = ack & grant_q[CH0];
  assign ch1_ack  = ack & grant_q[CH1];
  assign grant    = grant_q;
  assign pad_evt  = pad_q;
  assign busy     = state_q != ST_IDLE;
endmodule
